// File: rtl/gpio_access_arbiter_pkg.sv
// Shared definitions for the GPIO access arbiter: FSM encodings, GPIO register map
// and the request record carried from the winning requester into the sequencer.
package gpio_access_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  localparam int GPIO_IDAT   = 0;
  localparam int GPIO_OENA   = 1;
  localparam int GPIO_ODAT   = 2;
  localparam int PORT_STRIDE = 4;

  localparam int REQ_ADDR_W = 8;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [3:0]            be;
    logic [31:0]           wdata;
  } req_t;

  function automatic logic [REQ_ADDR_W-1:0] gpio_word_addr(input int port, input int reg_ofs);
    return REQ_ADDR_W'(port * PORT_STRIDE + reg_ofs);
  endfunction

endpackage

// File: rtl/gpio_access_arbiter_rr_arbiter.sv
// Round-robin picker: grants the first valid requester at or above ptr (wrapping);
// purely combinational, the caller registers next_ptr.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr
);

  logic          found;
  logic [PW-1:0] winner;
  logic [PW-1:0] idx;

  always_comb begin
    grant  = '0;
    found  = 1'b0;
    winner = ptr;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

  // The pointer only moves past a requester that actually won this cycle.
  always_comb begin
    next_ptr = ptr;
    if (advance && found) next_ptr = PW'((int'(winner) + 1) % N);
  end

endmodule

// File: rtl/gpio_access_arbiter.sv
// Shares the GPIO register port among NREQ requesters, one access at a time, round-robin;
// writes take 3 cycles, reads 4 (including the GPIO's registered read), then a response pulse.
module gpio_access_arbiter
  import gpio_access_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*8-1:0]    req_addr,
  input  logic [NREQ*4-1:0]    req_be,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_rdata,
  output logic [ADDR_W-1:0]    gpio_addr_in,
  output logic [3:0]           gpio_size_decode,
  output logic [31:0]          gpio_data_in,
  output logic [ADDR_W-1:0]    gpio_addr_out,
  input  logic [31:0]          gpio_data_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_ptr_nxt;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] owner;
  logic            in_idle;
  logic            accept;
  req_t            win_req;

  assign in_idle   = (state == ST_IDLE);
  assign req_ready = grant & {NREQ{in_idle}};
  assign accept    = |req_ready;

  rr_arbiter #(.N(NREQ)) u_rr (
    .valid    (req_valid),
    .ptr      (rr_ptr),
    .advance  (in_idle),
    .grant    (grant),
    .next_ptr (rr_ptr_nxt)
  );

  always_comb begin
    win_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_req = '{write: req_write[i], addr: req_addr[i*8 +: 8],
                    be: req_be[i*4 +: 4], wdata: req_wdata[i*32 +: 32]};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = win_req.write ? ST_WRITE : ST_RD_ADDR;
      ST_WRITE:   state_nxt = ST_RESP;
      ST_RD_ADDR: state_nxt = ST_RD_DATA;
      ST_RD_DATA: state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // GPIO-side registers double as the latched request; the strobe and response are single-cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner            <= '0;
      resp_valid       <= '0;
      resp_rdata       <= '0;
      gpio_addr_in     <= '0;
      gpio_size_decode <= '0;
      gpio_data_in     <= '0;
      gpio_addr_out    <= '0;
    end else begin
      resp_valid       <= '0;
      gpio_size_decode <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner <= req_ready;
            if (win_req.write) begin
              gpio_addr_in     <= ADDR_W'(win_req.addr);
              gpio_size_decode <= win_req.be;
              gpio_data_in     <= win_req.wdata;
            end else begin
              gpio_addr_out <= ADDR_W'(win_req.addr);
            end
          end
        end
        ST_WRITE:   resp_valid <= owner;
        ST_RD_DATA: begin
          resp_rdata <= gpio_data_out;
          resp_valid <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Bench for gpio_access_arbiter: GPIO register-file stand-in, a transaction-timeline model
// checked every cycle, and directed scenarios with literal expectations.
module tb_gpio_access_arbiter;
  import gpio_access_arbiter_pkg::*;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 8;

  logic                clk  = 1'b0;
  logic                rstn = 1'b0;
  logic [NREQ-1:0]     req_valid, req_ready, req_write, resp_valid;
  logic [NREQ*8-1:0]   req_addr;
  logic [NREQ*4-1:0]   req_be;
  logic [NREQ*32-1:0]  req_wdata;
  logic [31:0]         resp_rdata, gpio_data_in, gpio_data_out;
  logic [ADDR_W-1:0]   gpio_addr_in, gpio_addr_out;
  logic [3:0]          gpio_size_decode;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpio_access_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .gpio_addr_in(gpio_addr_in), .gpio_size_decode(gpio_size_decode),
    .gpio_data_in(gpio_data_in), .gpio_addr_out(gpio_addr_out),
    .gpio_data_out(gpio_data_out)
  );

  // GPIO register file: byte-strobed writes, one-cycle registered reads.
  logic [31:0] gmem [256];
  initial foreach (gmem[i]) gmem[i] = 32'h0;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (gpio_size_decode[b]) gmem[gpio_addr_in][b*8 +: 8] <= gpio_data_in[b*8 +: 8];
    gpio_data_out <= gmem[gpio_addr_out];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted access is a timeline of "age" cycles after the handshake edge.
  int          age = 0, m_owner = 0, m_ptr = 0, win = -1, idx = 0;
  logic        m_write = 1'b0;
  logic [7:0]  m_addr = '0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_mem [256];
  logic [7:0]  e_addr_in = '0, e_addr_out = '0;
  logic [31:0] e_data_in = '0, e_rdata = '0;
  logic [NREQ-1:0] e_ready, e_resp;
  logic [3:0]  e_size;
  int          resp_cnt [NREQ];
  initial begin
    foreach (m_mem[i]) m_mem[i] = 32'h0;
    foreach (resp_cnt[i]) resp_cnt[i] = 0;
  end

  always @(negedge clk) begin
    if (!rstn) begin
      age = 0; m_ptr = 0;
      e_addr_in = '0; e_addr_out = '0; e_data_in = '0; e_rdata = '0;
      chk("rst_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_size", gpio_size_decode, 0);
      chk("rst_addr_in", gpio_addr_in, 0);
      chk("rst_addr_out", gpio_addr_out, 0);
      chk("rst_data_in", gpio_data_in, 0);
    end else begin
      e_ready = '0; e_resp = '0; e_size = '0; win = -1;
      if (age == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (win < 0 && req_valid[idx]) win = idx;
        end
        if (win >= 0) e_ready[win] = 1'b1;
      end else if (m_write) begin
        if (age == 1) e_size = m_be;
        if (age == 2) e_resp[m_owner] = 1'b1;
      end else if (age == 3) begin
        e_resp[m_owner] = 1'b1;
      end
      chk("m_ready", req_ready, e_ready);
      chk("m_resp_valid", resp_valid, e_resp);
      chk("m_size", gpio_size_decode, e_size);
      chk("m_addr_in", gpio_addr_in, e_addr_in);
      chk("m_data_in", gpio_data_in, e_data_in);
      chk("m_addr_out", gpio_addr_out, e_addr_out);
      chk("m_rdata", resp_rdata, e_rdata);
      for (int i = 0; i < NREQ; i++) if (resp_valid[i]) resp_cnt[i]++;
      if (age == 0) begin
        if (win >= 0) begin
          m_owner = win; m_write = req_write[win]; m_addr = req_addr[win*8 +: 8];
          m_be = req_be[win*4 +: 4]; m_wdata = req_wdata[win*32 +: 32];
          m_ptr = (win + 1) % NREQ; age = 1;
          if (m_write) begin e_addr_in = m_addr; e_data_in = m_wdata; end
          else e_addr_out = m_addr;
        end
      end else begin
        if (m_write && age == 1)
          for (int b = 0; b < 4; b++) if (m_be[b]) m_mem[m_addr][b*8 +: 8] = m_wdata[b*8 +: 8];
        if (!m_write && age == 2) e_rdata = m_mem[m_addr];
        age = ((m_write && age == 2) || (!m_write && age == 3)) ? 0 : age + 1;
      end
    end
  end

  task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [3:0] be,
                         input logic [31:0] d);
    req_write[i] = w; req_addr[i*8 +: 8] = a; req_be[i*4 +: 4] = be; req_wdata[i*32 +: 32] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[i] && n < 40);
    chk("ready_wait", req_ready[i], 1);
  endtask

  task automatic wait_resp(input int i, output int lat, output logic [31:0] rd);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid[i] && lat < 40);
    rd = resp_rdata;
    chk("resp_wait", resp_valid[i], 1);
  endtask

  task automatic access(input int i, input logic w, input logic [7:0] a, input logic [3:0] be,
                        input logic [31:0] d, output int lat, output logic [31:0] rd);
    set_req(i, w, a, be, d);
    wait_ready(i);
    @(posedge clk); #1 req_valid[i] = 1'b0;
    wait_resp(i, lat, rd);
    @(posedge clk); #1;
  endtask

  int          lat, n, c0, c1;
  logic [31:0] rd;
  logic [NREQ-1:0] t3_exp [4];

  initial begin
    t3_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
    req_valid = '0; req_write = '0; req_addr = '0; req_be = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // 1: single write, exact strobe/response timing
    set_req(0, 1'b1, gpio_word_addr(0, GPIO_ODAT), 4'hF, 32'hA5A5_0F0F);
    @(negedge clk); chk("t1_ready", req_ready, 2'b01);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk); chk("t1_strobe", gpio_size_decode, 4'hF);
    chk("t1_addr_in", gpio_addr_in, 8'd2);
    chk("t1_data_in", gpio_data_in, 32'hA5A5_0F0F);
    @(negedge clk); chk("t1_strobe_off", gpio_size_decode, 4'h0);
    chk("t1_resp", resp_valid, 2'b01);
    @(posedge clk); #1 set_req(0, 1'b0, 8'd2, 4'h0, 32'h0);
    @(negedge clk); chk("t1_ready_again", req_ready, 2'b01);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_resp(0, lat, rd);
    chk("t1_rd_lat", lat, 3);
    chk("t1_rd_data", rd, 32'hA5A5_0F0F);
    @(posedge clk); #1;

    // 2: read after write
    access(0, 1'b1, gpio_word_addr(0, GPIO_OENA), 4'hF, 32'h0000_00FF, lat, rd);
    chk("t2_wr_lat", lat, 2);
    access(0, 1'b1, gpio_word_addr(0, GPIO_ODAT), 4'hF, 32'h0000_0055, lat, rd);
    access(0, 1'b0, gpio_word_addr(0, GPIO_ODAT), 4'h0, 32'h0, lat, rd);
    chk("t2_rd_lat", lat, 3);
    chk("t2_rd_data", rd, 32'h0000_0055);

    // 3: contention; pointer sits at 1 after the req0-only traffic above
    c0 = resp_cnt[0]; c1 = resp_cnt[1];
    set_req(0, 1'b1, 8'd6, 4'hF, 32'h1111_0000);
    set_req(1, 1'b1, 8'd10, 4'hF, 32'h2222_0000);
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(|req_ready) && n < 20);
      chk("t3_grant", req_ready, t3_exp[g]);
      @(posedge clk);
    end
    #1 req_valid = '0;
    repeat (4) @(negedge clk);
    chk("t3_resp0", resp_cnt[0] - c0, 2);
    chk("t3_resp1", resp_cnt[1] - c1, 2);
    @(posedge clk); #1;

    // 4: byte enables and be=0 no-op write
    access(0, 1'b1, gpio_word_addr(1, GPIO_OENA), 4'b0010, 32'hFFFF_FFFF, lat, rd);
    access(0, 1'b0, gpio_word_addr(1, GPIO_OENA), 4'h0, 32'h0, lat, rd);
    chk("t4_be_data", rd, 32'h0000_FF00);
    access(0, 1'b1, gpio_word_addr(1, GPIO_OENA), 4'b0000, 32'h1234_5678, lat, rd);
    chk("t4_be0_lat", lat, 2);
    access(0, 1'b0, gpio_word_addr(1, GPIO_OENA), 4'h0, 32'h0, lat, rd);
    chk("t4_be0_data", rd, 32'h0000_FF00);

    // 5: req1 pulses while req0 owns the port
    set_req(0, 1'b0, 8'd2, 4'h0, 32'h0);
    wait_ready(0);
    c1 = resp_cnt[1];
    @(posedge clk); #1 req_valid[0] = 1'b0; set_req(1, 1'b1, 8'd10, 4'hF, 32'hDEAD_BEEF);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_resp(0, lat, rd);
    chk("t5_rd0", rd, 32'h0000_0055);
    @(posedge clk); #1;
    chk("t5_no_resp1", resp_cnt[1] - c1, 0);
    set_req(0, 1'b0, 8'd2, 4'h0, 32'h0);
    set_req(1, 1'b0, 8'd6, 4'h0, 32'h0);
    @(negedge clk); chk("t5_ptr", req_ready, 2'b10);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_resp(1, lat, rd);
    chk("t5_rd1", rd, 32'h1111_0000);
    wait_ready(0);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_resp(0, lat, rd);
    chk("t5_rd0b", rd, 32'h0000_0055);
    @(posedge clk); #1;

    // 6: reset while in RD_DATA
    set_req(0, 1'b0, 8'd6, 4'h0, 32'h0);
    wait_ready(0);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("t6_pre_addr_out", gpio_addr_out, 8'd6);
    rstn = 1'b0;
    #1;
    chk("t6_addr_out", gpio_addr_out, 0);
    chk("t6_resp_valid", resp_valid, 0);
    chk("t6_size", gpio_size_decode, 0);
    chk("t6_rdata", resp_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    access(0, 1'b0, 8'd2, 4'h0, 32'h0, lat, rd);
    chk("t6_fresh_lat", lat, 3);
    chk("t6_fresh_data", rd, 32'h0000_0055);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1);
  end

endmodule
